// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake and an optional shift-add multiplier.
// Define ALU_SEQ_MUL_EN to build the multiplier; otherwise SEL=111 flags ERR.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [2:0]       SEL,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic [WIDTH-1:0] DATA_HI,
  output logic             Cnext,
  output logic             ZERO,
  output logic             ERR,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] dhi_q, dhi_d;
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_err;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_step;

  // One step: add multiplicand to the upper half if LSB set, then shift right.
  always_comb begin
    mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
    if (prod_q[0]) begin
      mul_sum = mul_sum + {1'b0, mcand_q};
    end
    prod_step = {mul_sum, prod_q[WIDTH-1:1]};
  end
`endif

  always_comb begin
    sum_w   = {1'b0, X} + {1'b0, Y};
    diff_w  = {1'b0, X} - {1'b0, Y};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_err = 1'b0;
    unique case (SEL)
      3'b000: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
      end
      3'b001: begin
        alu_res = diff_w[WIDTH-1:0];
        alu_c   = ~diff_w[WIDTH];
      end
      3'b010: alu_res = X & Y;
      3'b011: alu_res = X | Y;
      3'b100: alu_res = X ^ Y;
      3'b101: begin
        alu_res = {X[WIDTH-2:0], 1'b0};
        alu_c   = X[WIDTH-1];
      end
      3'b110: begin
        alu_res = {1'b0, X[WIDTH-1:1]};
        alu_c   = X[0];
      end
      3'b111: begin
`ifndef ALU_SEQ_MUL_EN
        alu_err = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    dhi_d   = dhi_q;
    c_d     = c_q;
    z_d     = z_q;
    err_d   = err_q;
`ifdef ALU_SEQ_MUL_EN
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (IN_VALID) begin
`ifdef ALU_SEQ_MUL_EN
          if (SEL == 3'b111) begin
            state_d = BUSY;
            mcand_d = X;
            prod_d  = {{WIDTH{1'b0}}, Y};
            cnt_d   = '0;
          end else
`endif
          begin
            state_d = DONE;
            dout_d  = alu_res;
            dhi_d   = '0;
            c_d     = alu_c;
            z_d     = (alu_res == '0);
            err_d   = alu_err;
          end
        end
      end
      BUSY: begin
`ifdef ALU_SEQ_MUL_EN
        prod_d = prod_step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          dout_d  = prod_step[WIDTH-1:0];
          dhi_d   = prod_step[2*WIDTH-1:WIDTH];
          c_d     = |prod_step[2*WIDTH-1:WIDTH];
          z_d     = (prod_step == '0);
          err_d   = 1'b0;
        end
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        if (OUT_READY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      dout_q  <= '0;
      dhi_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      err_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      dhi_q   <= dhi_d;
      c_q     <= c_d;
      z_q     <= z_d;
      err_q   <= err_d;
`ifdef ALU_SEQ_MUL_EN
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign IN_READY  = (state_q == IDLE);
  assign OUT_VALID = (state_q == DONE);
  assign DATA_OUT  = dout_q;
  assign DATA_HI   = dhi_q;
  assign Cnext     = c_q;
  assign ZERO      = z_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8); MUL checks follow ALU_SEQ_MUL_EN.
module tb_alu_seq;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] X, Y;
  logic [2:0] SEL;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] DATA_OUT, DATA_HI;
  logic       Cnext, ZERO, ERR;
  logic       OUT_VALID;
  logic       OUT_READY;

  int vectors = 0;
  int errs    = 0;

  alu_seq #(.WIDTH(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .X(X), .Y(Y), .SEL(SEL),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .DATA_OUT(DATA_OUT), .DATA_HI(DATA_HI),
    .Cnext(Cnext), .ZERO(ZERO), .ERR(ERR),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present one op for exactly one edge, then scramble the inputs.
  task automatic issue(input logic [2:0] s, input logic [7:0] a,
                       input logic [7:0] b);
    SEL = s; X = a; Y = b; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    X = 8'h5A; Y = 8'hA5; SEL = 3'b011;
  endtask

  task automatic res(input string tag, input logic [7:0] lo,
                     input logic [7:0] hi, input logic c,
                     input logic z, input logic e);
    chk({tag, ".valid"}, OUT_VALID, 1'b1);
    chk({tag, ".lo"}, DATA_OUT, lo);
    chk({tag, ".hi"}, DATA_HI, hi);
    chk({tag, ".c"}, Cnext, c);
    chk({tag, ".z"}, ZERO, z);
    chk({tag, ".err"}, ERR, e);
  endtask

  // Release with a competing request on the same edge; it must be ignored.
  task automatic drain(input string tag);
    OUT_READY = 1'b1; IN_VALID = 1'b1; SEL = 3'b000; X = 8'h01; Y = 8'h01;
    tick();
    OUT_READY = 1'b0; IN_VALID = 1'b0;
    chk({tag, ".drain_ov"}, OUT_VALID, 1'b0);
    chk({tag, ".drain_ir"}, IN_READY, 1'b1);
  endtask

  initial begin
    RST_N = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    X = 8'h00; Y = 8'h00; SEL = 3'b000;
    tick(); tick();
    RST_N = 1'b1;
    chk("rst.ir", IN_READY, 1'b1);
    chk("rst.ov", OUT_VALID, 1'b0);
    chk("rst.lo", DATA_OUT, 8'h00);
    chk("rst.hi", DATA_HI, 8'h00);
    chk("rst.c", Cnext, 1'b0);
    chk("rst.z", ZERO, 1'b0);
    chk("rst.err", ERR, 1'b0);

    issue(3'b000, 8'hFF, 8'h01);
    res("add_ff_01", 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("add.ir", IN_READY, 1'b0);
    drain("add");
    chk("add.hold_idle", DATA_OUT, 8'h00);

    issue(3'b001, 8'h05, 8'h07);
    res("sub_05_07", 8'hFE, 8'h00, 1'b0, 1'b0, 1'b0);
    drain("sub1");
    issue(3'b001, 8'h07, 8'h05);
    res("sub_07_05", 8'h02, 8'h00, 1'b1, 1'b0, 1'b0);
    drain("sub2");
    issue(3'b001, 8'h33, 8'h33);
    res("sub_eq", 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    drain("sub3");
    issue(3'b101, 8'h81, 8'hFF);
    res("shl_81", 8'h02, 8'h00, 1'b1, 1'b0, 1'b0);
    drain("shl");
    issue(3'b110, 8'h81, 8'hFF);
    res("shr_81", 8'h40, 8'h00, 1'b1, 1'b0, 1'b0);
    drain("shr");
    issue(3'b000, 8'h12, 8'h34);
    res("add_12_34", 8'h46, 8'h00, 1'b0, 1'b0, 1'b0);
    drain("add2");
    issue(3'b011, 8'h0F, 8'h30);
    res("or", 8'h3F, 8'h00, 1'b0, 1'b0, 1'b0);
    drain("or");
    issue(3'b100, 8'h5A, 8'hFF);
    res("xor", 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0);
    drain("xor");

    issue(3'b010, 8'hF0, 8'h3C);
    IN_VALID = 1'b1; SEL = 3'b000; X = 8'h11; Y = 8'h22;
    for (int i = 0; i < 3; i++) begin
      res("and_bp", 8'h30, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("and_bp.ir", IN_READY, 1'b0);
      tick();
    end
    res("and_bp_end", 8'h30, 8'h00, 1'b0, 1'b0, 1'b0);
    IN_VALID = 1'b0;
    drain("and");
    chk("and.hold_idle", DATA_OUT, 8'h30);

`ifdef ALU_SEQ_MUL_EN
    // Acceptance edge plus 8 more: OUT_VALID on the 9th edge.
    issue(3'b111, 8'hFF, 8'hFF);
    for (int i = 1; i < 8; i++) begin
      chk("mul.busy_ov", OUT_VALID, 1'b0);
      chk("mul.busy_ir", IN_READY, 1'b0);
      chk("mul.busy_hold", DATA_OUT, 8'h30);
      tick();
    end
    chk("mul.pre_ov", OUT_VALID, 1'b0);
    chk("mul.pre_ir", IN_READY, 1'b0);
    tick();
    res("mul_ff_ff", 8'h01, 8'hFE, 1'b1, 1'b0, 1'b0);
    drain("mul1");
    issue(3'b111, 8'h0D, 8'h0B);
    repeat (8) tick();
    res("mul_0d_0b", 8'h8F, 8'h00, 1'b0, 1'b0, 1'b0);
    drain("mul2");
    issue(3'b111, 8'h00, 8'h05);
    repeat (8) tick();
    res("mul_zero", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    drain("mul3");

    issue(3'b000, 8'h10, 8'h20);
    drain("pre_abort");
    issue(3'b111, 8'h07, 8'h09);
    repeat (3) tick();
    RST_N = 1'b0; OUT_READY = 1'b1; IN_VALID = 1'b1; SEL = 3'b111;
    tick();
    RST_N = 1'b1; OUT_READY = 1'b0; IN_VALID = 1'b0;
`else
    issue(3'b111, 8'h03, 8'h04);
    res("mul_off", 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    drain("mul_off");
    issue(3'b000, 8'h01, 8'h02);
    res("err_clr", 8'h03, 8'h00, 1'b0, 1'b0, 1'b0);
    drain("err_clr");

    issue(3'b000, 8'hFF, 8'h02);
    RST_N = 1'b0; OUT_READY = 1'b1; IN_VALID = 1'b1; SEL = 3'b000;
    tick();
    RST_N = 1'b1; OUT_READY = 1'b0; IN_VALID = 1'b0;
`endif
    chk("abort.ir", IN_READY, 1'b1);
    chk("abort.ov", OUT_VALID, 1'b0);
    chk("abort.lo", DATA_OUT, 8'h00);
    chk("abort.hi", DATA_HI, 8'h00);
    chk("abort.c", Cnext, 1'b0);
    chk("abort.z", ZERO, 1'b0);
    chk("abort.err", ERR, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("abort.no_ov", OUT_VALID, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
